// File: rtl/noc_pkg.sv
// Shared NoC types for the ejection NIC: flit type encoding, default sizing, head test.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Also supplies a default for the FLIT_DATA_WIDTH macro when the build does not set one.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package noc_pkg;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;

    localparam int NUM_VC   = 4;
    localparam int VC_DEPTH = 4;
    localparam int VC_W     = $clog2(NUM_VC);

    // A flit that opens a packet: HEAD or single-flit HEAD_TAIL.
    function automatic logic is_head(input logic [1:0] t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/nic_eject_if.sv
// Router-to-NIC flit/credit signals plus the NIC-to-core flit offer, bundled.
// Latency: n/a (wires only).
// Backpressure: core uses out_flit_ready; router is throttled by returned credits.
// Ports: in_* (router flit), credit_* (to router), out_* (to core), err_overflow.
// master = the ejection NIC, slave = its environment (router + core).
interface nic_eject_if #(
    parameter int VC_W = noc_pkg::VC_W,
    parameter int DW   = `FLIT_DATA_WIDTH
);
    logic            in_flit_valid;
    logic [DW-1:0]   in_flit;
    logic [1:0]      in_flit_type;
    logic [VC_W-1:0] in_vc;
    logic            credit_valid;
    logic [VC_W-1:0] credit_vc;
    logic            out_flit_valid;
    logic [DW-1:0]   out_flit;
    logic [1:0]      out_flit_type;
    logic [VC_W-1:0] out_vc;
    logic            out_flit_ready;
    logic            err_overflow;

    modport master (
        input  in_flit_valid, in_flit, in_flit_type, in_vc, out_flit_ready,
        output credit_valid, credit_vc, out_flit_valid, out_flit, out_flit_type, out_vc,
        err_overflow
    );

    modport slave (
        output in_flit_valid, in_flit, in_flit_type, in_vc, out_flit_ready,
        input  credit_valid, credit_vc, out_flit_valid, out_flit, out_flit_type, out_vc,
        err_overflow
    );
endinterface

// File: rtl/nic_vc_fifo.sv
// Per-VC flit FIFO with an occupancy counter; front entry readable combinationally.
// Latency: a pushed entry is visible at front_dat the cycle after the push.
// Backpressure: push while full is ignored unless a pop frees the slot the same cycle.
// Ports: clk, reset, push/push_dat, pop, full, empty, front_dat.
module nic_vc_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] front_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok, pop_ok;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign front_dat = mem[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        // A simultaneous pop frees the slot, so a full FIFO can still accept.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_dat;
    end
endmodule

// File: rtl/nic_eject.sv
// Ejection NIC: per-VC buffering, packet-locked round-robin delivery to the core, credit return.
// Latency: flit offered >=1 cycle after push (combinational output); credit 1 cycle after pop.
// Backpressure: out_flit_ready stalls the offer in place; router is paced by returned credits.
// Ports: clk, reset (sync, active-high), bus (nic_eject_if.master).
// Optional NIC_EJECT_STATS_EN adds stat_pkt_count / stat_flit_count outputs.
module nic_eject #(
    parameter int NUM_VC   = noc_pkg::NUM_VC,
    parameter int VC_DEPTH = noc_pkg::VC_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    nic_eject_if.master       bus
`ifdef NIC_EJECT_STATS_EN
    ,
    output logic [31:0]       stat_pkt_count,
    output logic [31:0]       stat_flit_count
`endif
);
    import noc_pkg::is_head;
    import noc_pkg::HEAD;
    import noc_pkg::TAIL;
    import noc_pkg::HEAD_TAIL;

    localparam int VCW = $clog2(NUM_VC);
    localparam int DW  = `FLIT_DATA_WIDTH;
    localparam int FW  = DW + 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [FW-1:0]     front_dat [NUM_VC];
    logic [NUM_VC-1:0] full, empty, push_vec, pop_vec;

    logic [0:0]        state_q, state_d;
    logic [VCW-1:0]    lock_vc_q, lock_vc_d, rr_ptr_q, rr_ptr_d;
    logic              credit_valid_q, credit_valid_d;
    logic [VCW-1:0]    credit_vc_q, credit_vc_d;
    logic              err_overflow_q, err_overflow_d;

    logic              sel_vld, pop;
    logic [VCW-1:0]    sel_vc, idx;
    logic [FW-1:0]     sel_dat;
    logic [1:0]        sel_type;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        nic_vc_fifo #(.WIDTH(FW), .DEPTH(VC_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_vec[g]),
            .push_dat  ({bus.in_flit, bus.in_flit_type}),
            .pop       (pop_vec[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .front_dat (front_dat[g])
        );
    end

    // Selection: round-robin over head-fronted VCs when idle, the locked VC otherwise.
    always_comb begin
        sel_vld = 1'b0;
        sel_vc  = '0;
        idx     = '0;
        if (state_q == ST_IDLE) begin
            for (int i = 0; i < NUM_VC; i++) begin
                idx = rr_ptr_q + VCW'(i);
                if (!sel_vld && !empty[idx] && is_head(front_dat[idx][1:0])) begin
                    sel_vld = 1'b1;
                    sel_vc  = idx;
                end
            end
        end else begin
            sel_vc  = lock_vc_q;
            sel_vld = !empty[lock_vc_q];
        end
        sel_dat  = front_dat[sel_vc];
        sel_type = sel_dat[1:0];
        pop      = sel_vld && bus.out_flit_ready;
        for (int i = 0; i < NUM_VC; i++) begin
            push_vec[i] = bus.in_flit_valid && (bus.in_vc == VCW'(i));
            pop_vec[i]  = pop && (sel_vc == VCW'(i));
        end
    end

    // Output fields read as zero whenever nothing is offered.
    assign bus.out_flit_valid = sel_vld;
    assign bus.out_vc         = sel_vld ? sel_vc : '0;
    assign bus.out_flit       = sel_vld ? sel_dat[FW-1:2] : '0;
    assign bus.out_flit_type  = sel_vld ? sel_type : '0;
    assign bus.credit_valid   = credit_valid_q;
    assign bus.credit_vc      = credit_vc_q;
    assign bus.err_overflow   = err_overflow_q;

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (pop) begin
            if (state_q == ST_IDLE) begin
                // Only HEAD or HEAD_TAIL can be selected while idle.
                if (sel_type == HEAD) begin
                    state_d   = ST_LOCKED;
                    lock_vc_d = sel_vc;
                end else begin
                    rr_ptr_d = sel_vc + VCW'(1);
                end
            end else if (sel_type == TAIL) begin
                state_d  = ST_IDLE;
                rr_ptr_d = lock_vc_q + VCW'(1);
            end
        end
        credit_valid_d = pop;
        credit_vc_d    = pop ? sel_vc : '0;
        // A same-cycle pop of the target VC frees its slot, so that is not an overflow.
        err_overflow_d = err_overflow_q | (|(full & push_vec & ~pop_vec));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            lock_vc_q      <= '0;
            rr_ptr_q       <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lock_vc_q      <= lock_vc_d;
            rr_ptr_q       <= rr_ptr_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
            err_overflow_q <= err_overflow_d;
        end
    end

`ifdef NIC_EJECT_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d, flit_cnt_q, flit_cnt_d;

    always_comb begin
        flit_cnt_d = flit_cnt_q + 32'(pop);
        pkt_cnt_d  = pkt_cnt_q + 32'(pop && (sel_type == TAIL || sel_type == HEAD_TAIL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_flit_count = flit_cnt_q;
`endif
endmodule

// File: tb/tb_nic_eject.sv
// Directed, table-driven bench for nic_eject: one vector per clock cycle.
// Inputs driven on the falling edge; outputs compared 1 time unit later.
// Expected values are hand-derived per cycle in the table below.
module tb_nic_eject;
    localparam int DW = `FLIT_DATA_WIDTH;
    localparam int BD = 0, HD = 1, TL = 2, HT = 3;

    typedef struct {
        logic          rst;
        logic          in_vld;
        logic [1:0]    in_type;
        logic [1:0]    in_vc;
        logic [DW-1:0] in_dat;
        logic          rdy;
        logic          x_vld;
        logic [1:0]    x_vc;
        logic [1:0]    x_type;
        logic [DW-1:0] x_dat;
        logic          x_cv;
        logic [1:0]    x_cvc;
        logic          x_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nic_eject_if #(.VC_W(2), .DW(DW)) bus_if();

`ifdef NIC_EJECT_STATS_EN
    logic [31:0] stat_pkt_count, stat_flit_count;
`endif

    nic_eject #(.NUM_VC(4), .VC_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef NIC_EJECT_STATS_EN
        ,
        .stat_pkt_count  (stat_pkt_count),
        .stat_flit_count (stat_flit_count)
`endif
    );

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input int r, iv, it, ivc, id, rd, xv, xvc, xt, xd, xc, xcv, xe);
        vec_t v;
        v.rst = 1'(r);  v.in_vld = 1'(iv); v.in_type = 2'(it); v.in_vc = 2'(ivc);
        v.in_dat = DW'(id); v.rdy = 1'(rd);
        v.x_vld = 1'(xv); v.x_vc = 2'(xvc); v.x_type = 2'(xt); v.x_dat = DW'(xd);
        v.x_cv = 1'(xc); v.x_cvc = 2'(xcv); v.x_err = 1'(xe);
        return v;
    endfunction

    // No push this cycle.
    function automatic vec_t nop(input int rd, xv, xvc, xt, xd, xc, xcv, xe);
        return mk(0, 0, 0, 0, 0, rd, xv, xvc, xt, xd, xc, xcv, xe);
    endfunction

    task automatic check(input vec_t v, input int k);
        logic ok;
        ok = (bus_if.out_flit_valid === v.x_vld) && (bus_if.credit_valid === v.x_cv) &&
             (bus_if.err_overflow === v.x_err);
        if (v.x_vld)
            ok = ok && (bus_if.out_vc === v.x_vc) && (bus_if.out_flit_type === v.x_type) &&
                 (bus_if.out_flit === v.x_dat);
        if (v.x_cv) ok = ok && (bus_if.credit_vc === v.x_cvc);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL vec%0d: got vld=%b vc=%0d typ=%0d dat=%h credit=%b/%0d err=%b; want vld=%b vc=%0d typ=%0d dat=%h credit=%b/%0d err=%b",
                     k, bus_if.out_flit_valid, bus_if.out_vc, bus_if.out_flit_type, bus_if.out_flit,
                     bus_if.credit_valid, bus_if.credit_vc, bus_if.err_overflow,
                     v.x_vld, v.x_vc, v.x_type, v.x_dat, v.x_cv, v.x_cvc, v.x_err);
        end
    endtask

    task automatic apply(input vec_t v, input int k);
        @(negedge clk);
        reset                = v.rst;
        bus_if.in_flit_valid = v.in_vld;
        bus_if.in_flit_type  = v.in_type;
        bus_if.in_vc         = v.in_vc;
        bus_if.in_flit       = v.in_dat;
        bus_if.out_flit_ready = v.rdy;
        #1;
        check(v, k);
    endtask

    initial begin
        reset = 1'b1;
        bus_if.in_flit_valid = 1'b0;
        bus_if.in_flit_type  = '0;
        bus_if.in_vc         = '0;
        bus_if.in_flit       = '0;
        bus_if.out_flit_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus_if.out_flit_valid !== 1'b0 || bus_if.credit_valid !== 1'b0 ||
            bus_if.err_overflow !== 1'b0 || bus_if.credit_vc !== 2'd0 || bus_if.out_vc !== 2'd0 ||
            bus_if.out_flit !== '0 || bus_if.out_flit_type !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: got vld=%b credit=%b/%0d err=%b vc=%0d dat=%h typ=%0d; want all zero",
                     bus_if.out_flit_valid, bus_if.credit_valid, bus_if.credit_vc, bus_if.err_overflow,
                     bus_if.out_vc, bus_if.out_flit, bus_if.out_flit_type);
        end

        // Single-flit packet on VC2.
        tbl.push_back(mk(0, 1, HT, 2, 'hA0, 1,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(nop(1,                     1, 2, HT, 'hA0,  0, 0, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      1, 2, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      0, 0, 0));
        // No interleave: VC0 and VC1 packets pushed alternately (rr_ptr=3).
        tbl.push_back(mk(0, 1, HD, 0, 'hB0, 1,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(0, 1, HD, 1, 'hC0, 1,  1, 0, HD, 'hB0,  0, 0, 0));
        tbl.push_back(mk(0, 1, BD, 0, 'hB1, 1,  0, 0, 0, 0,      1, 0, 0));
        tbl.push_back(mk(0, 1, BD, 1, 'hC1, 1,  1, 0, BD, 'hB1,  0, 0, 0));
        tbl.push_back(mk(0, 1, TL, 0, 'hB2, 1,  0, 0, 0, 0,      1, 0, 0));
        tbl.push_back(mk(0, 1, TL, 1, 'hC2, 1,  1, 0, TL, 'hB2,  0, 0, 0));
        tbl.push_back(nop(1,                     1, 1, HD, 'hC0,  1, 0, 0));
        tbl.push_back(nop(1,                     1, 1, BD, 'hC1,  1, 1, 0));
        tbl.push_back(nop(1,                     1, 1, TL, 'hC2,  1, 1, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      1, 1, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      0, 0, 0));
        // Backpressure, fill VC3, overflow on the 5th flit, then drain (rr_ptr=2).
        tbl.push_back(mk(0, 1, HD, 3, 'hE0, 0,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(0, 1, BD, 3, 'hE1, 0,  1, 3, HD, 'hE0,  0, 0, 0));
        tbl.push_back(mk(0, 1, BD, 3, 'hE2, 0,  1, 3, HD, 'hE0,  0, 0, 0));
        tbl.push_back(mk(0, 1, TL, 3, 'hE3, 0,  1, 3, HD, 'hE0,  0, 0, 0));
        tbl.push_back(mk(0, 1, BD, 3, 'hE4, 0,  1, 3, HD, 'hE0,  0, 0, 0));
        tbl.push_back(nop(0,                     1, 3, HD, 'hE0,  0, 0, 1));
        tbl.push_back(nop(1,                     1, 3, HD, 'hE0,  0, 0, 1));
        tbl.push_back(nop(1,                     1, 3, BD, 'hE1,  1, 3, 1));
        tbl.push_back(nop(1,                     1, 3, BD, 'hE2,  1, 3, 1));
        tbl.push_back(nop(1,                     1, 3, TL, 'hE3,  1, 3, 1));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      1, 3, 1));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,       0, 0, 0, 0,      0, 0, 1));
        // Round-robin from rr_ptr=0 across all four VCs, then refill VC2 and VC0.
        tbl.push_back(mk(0, 1, HT, 2, 'hF2, 0,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 3, 'hF3, 0,  1, 2, HT, 'hF2,  0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 1, 'hF1, 0,  1, 2, HT, 'hF2,  0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 0, 'hF0, 0,  1, 1, HT, 'hF1,  0, 0, 0));
        tbl.push_back(nop(1,                     1, 0, HT, 'hF0,  0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 2, 'h62, 1,  1, 1, HT, 'hF1,  1, 0, 0));
        tbl.push_back(mk(0, 1, HT, 0, 'h60, 1,  1, 2, HT, 'hF2,  1, 1, 0));
        tbl.push_back(nop(1,                     1, 3, HT, 'hF3,  1, 2, 0));
        tbl.push_back(nop(1,                     1, 0, HT, 'h60,  1, 3, 0));
        tbl.push_back(nop(1,                     1, 2, HT, 'h62,  1, 0, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      1, 2, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      0, 0, 0));
        // Stray BODY is never eligible; then reset right after a HEAD pops (rr_ptr=3).
        tbl.push_back(mk(0, 1, BD, 1, 'h71, 1,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(0, 1, HD, 0, 'h80, 0,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(0, 1, BD, 0, 'h81, 0,  1, 0, HD, 'h80,  0, 0, 0));
        tbl.push_back(mk(0, 1, BD, 0, 'h82, 0,  1, 0, HD, 'h80,  0, 0, 0));
        tbl.push_back(mk(0, 1, TL, 0, 'h83, 1,  1, 0, HD, 'h80,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,       1, 0, BD, 'h81,  1, 0, 0));
        tbl.push_back(mk(0, 1, HT, 3, 'h93, 0,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 1, 'h91, 0,  1, 3, HT, 'h93,  0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 0, 'h90, 0,  1, 1, HT, 'h91,  0, 0, 0));
        tbl.push_back(nop(1,                     1, 0, HT, 'h90,  0, 0, 0));
        tbl.push_back(nop(1,                     1, 1, HT, 'h91,  1, 0, 0));
        tbl.push_back(nop(1,                     1, 3, HT, 'h93,  1, 1, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      1, 3, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      0, 0, 0));
        // Push into a full VC1 in the same cycle it pops: accepted, no overflow.
        tbl.push_back(mk(0, 1, HT, 1, 'hD0, 0,  0, 0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 1, 'hD1, 0,  1, 1, HT, 'hD0,  0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 1, 'hD2, 0,  1, 1, HT, 'hD0,  0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 1, 'hD3, 0,  1, 1, HT, 'hD0,  0, 0, 0));
        tbl.push_back(mk(0, 1, HT, 1, 'hD4, 1,  1, 1, HT, 'hD0,  0, 0, 0));
        tbl.push_back(nop(1,                     1, 1, HT, 'hD1,  1, 1, 0));
        tbl.push_back(nop(1,                     1, 1, HT, 'hD2,  1, 1, 0));
        tbl.push_back(nop(1,                     1, 1, HT, 'hD3,  1, 1, 0));
        tbl.push_back(nop(1,                     1, 1, HT, 'hD4,  1, 1, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      1, 1, 0));
        tbl.push_back(nop(1,                     0, 0, 0, 0,      0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

`ifdef NIC_EJECT_STATS_EN
        // Since the last reset: 3 single-flit packets, then 5 more on VC1.
        @(negedge clk);
        #1;
        n_vec++;
        if (stat_pkt_count !== 32'd8 || stat_flit_count !== 32'd8) begin
            n_bad++;
            $display("FAIL stats: got pkt=%0d flit=%0d; want pkt=8 flit=8",
                     stat_pkt_count, stat_flit_count);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/nic_eject.md
# nic_eject

Ejection-side network interface: receives flits from the local output port of the router, buffers them in per-virtual-channel FIFOs, and delivers whole packets to the core one flit at a time over a valid/ready interface. It returns one credit to the router per flit consumed, and it holds the output locked to one VC from head to tail so that packets never interleave at the core. It is the receive counterpart of the injection NIC and sits between the router's local port and the core.

## Interface
- NUM_VC, 4: virtual channels on the local port (power of 2, ≥2)
- VC_DEPTH, 4: flit slots per VC FIFO (power of 2, ≥2); must equal the router's initial credit count
- clk  input  1  clock; every state element updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_flit_valid  input  1  a flit is present from the router this cycle
- in_flit  input  `FLIT_DATA_WIDTH  flit payload
- in_flit_type  input  2  flit type: 00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL (single-flit packet)
- in_vc  input  $clog2(NUM_VC)  destination VC of the incoming flit
- credit_valid  output  1  one credit returned this cycle
- credit_vc  output  $clog2(NUM_VC)  VC that the credit belongs to
- out_flit_valid  output  1  a flit is offered to the core
- out_flit  output  `FLIT_DATA_WIDTH  payload of the offered flit
- out_flit_type  output  2  type of the offered flit
- out_vc  output  $clog2(NUM_VC)  VC the offered flit came from
- out_flit_ready  input  1  the core accepts the flit; a pop occurs when valid && ready
- err_overflow  output  1  sticky; set when a flit arrives at a full VC

## Operation
- Push: when in_flit_valid is high, {in_flit, in_flit_type} is written into FIFO[in_vc]. At most one push occurs per cycle.
- Full VC: if FIFO[in_vc] is full at a push, the flit is dropped, err_overflow is set, and the FIFO state is unchanged. err_overflow is cleared only by reset.
- Arbiter FSM has two states, IDLE and LOCKED(lock_vc).
  - IDLE:
    - A VC is eligible when its FIFO is non-empty and its front flit is HEAD or HEAD_TAIL.
    - Round-robin selection starts at rr_ptr and picks the first eligible VC; that VC's front flit is offered the same cycle.
    - If a HEAD flit pops, go to LOCKED(winner).
    - If a HEAD_TAIL flit pops, stay in IDLE and set rr_ptr = winner+1 (mod NUM_VC).
    - If no pop occurs, the state and rr_ptr are unchanged and the offer may change the next cycle.
  - LOCKED(v):
    - Offer the front flit of FIFO[v] when that FIFO is non-empty. Other VCs are not offered.
    - A TAIL pop moves the FSM to IDLE and sets rr_ptr = v+1.
    - A BODY pop keeps the FSM in LOCKED(v).
- A BODY or TAIL flit at the front of a non-locked VC is never eligible.
- Credit: every pop produces credit_valid=1 and credit_vc=popped VC on the following cycle. Credits are registered, and at most one is issued per cycle.
- Same-VC push and pop in one cycle is legal, including when the FIFO is full (the pop frees the slot, so no overflow occurs) and when it is empty (the new flit is not visible until the next cycle).
- Reset mid-packet:
  - all FIFOs are emptied;
  - the FSM returns to IDLE;
  - rr_ptr is set to 0;
  - any pending credit is discarded.
  - Re-synchronising credits with the router is the router's own reset responsibility.

## Timing
- Reset values:
  - out_flit_valid=0;
  - credit_valid=0;
  - err_overflow=0;
  - credit_vc=0, out_vc=0, out_flit=0, out_flit_type=0.
- Latency: a flit pushed in cycle N can first be offered in cycle N+1 (minimum). Its credit appears in the cycle after it pops.
- The output path is combinational from the FIFO read data and the arbiter state, with no output register. Sustained throughput is 1 flit/cycle.
- out_flit_valid may drop without a pop only in IDLE, and only when arbitration changes. Within a locked packet, an offered flit stays stable until it pops.

## Configuration
- NIC_EJECT_STATS_EN:
  - Defined: adds outputs stat_pkt_count[31:0], which increments on every TAIL or HEAD_TAIL pop, and stat_flit_count[31:0], which increments on every pop. Both counters reset to 0 and wrap modulo 2^32.
  - Not defined: the ports and the counters are absent; all other behaviour is identical.

## Structure
- Shared package `noc_pkg`:
  - flit_type_e enum (BODY/HEAD/TAIL/HEAD_TAIL, 2-bit);
  - helper is_head() (true for HEAD or HEAD_TAIL);
  - localparam VC_W = $clog2(NUM_VC).
- Sub-module `nic_vc_fifo`, instantiated NUM_VC times:
  - parameters: width and depth;
  - ports: push, pop, full, empty, front data;
  - uses an occupancy counter of $clog2(VC_DEPTH)+1 bits.
- The arbiter, the lock FSM and the credit register live in the top level.

## Test plan
- Single-flit packet: HEAD_TAIL on VC2 in cycle 0 with ready=1 → out_flit_valid=1, out_vc=2 in cycle 1; credit_valid=1, credit_vc=2 in cycle 2; FSM back in IDLE.
- No interleave: a 3-flit packet on VC0 and a 3-flit packet on VC1 pushed in alternating cycles, ready=1 → output sequence H0 B0 T0 H1 B1 T1, with exactly 6 credits.
- Backpressure and full: 4 flits pushed to VC3 with ready=0 → no credits, no error. A 5th push → flit dropped, err_overflow=1. Raising ready → 4 pops and 4 credits, each one cycle after its pop.
- Round-robin fairness: heads pending on all 4 VCs and rr_ptr=0 → service order VC0, VC1, VC2, VC3. Refilling VC0 and VC2 → next winner VC2 after VC3 completes? No: next winner is VC0 (rr_ptr wrapped to 0).
- Reset mid-packet: reset asserted after the HEAD of a 4-flit packet pops → next cycle out_flit_valid=0, credit_valid=0, FIFOs empty, IDLE; a fresh HEAD_TAIL then delivers normally.
- Stats (with NIC_EJECT_STATS_EN): deliver 3 packets totalling 7 flits → stat_pkt_count=3, stat_flit_count=7.
